arm_control_unit: RTL

- Multi-cycle Moore control unit that sequences the ARM datapath: fetch, decode, condition check, execute.
- Supported instruction classes: data-processing (immediate and register), LDR/STR word/byte with immediate offset, and B/BL.
- Drives every datapath control input. Consumes IR_Out, MFC and Flags from the datapath.
- Adds a memory-response timeout that aborts a hung memory access.

---
 rtl/arm_ctrl_pkg.sv | 72 +++++++
 rtl/arm_cond_eval.sv | 42 ++++
 rtl/arm_control_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM multi-cycle control unit.
// Contents: FSM state encodings, ALU opcodes (ARM data-processing encoding),
// datapath mux-select codes, memory transfer sizes and ARM condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F0  = 4'd1,
        S_F1  = 4'd2,
        S_F2  = 4'd3,
        S_F3  = 4'd4,
        S_DEC = 4'd5,
        S_DP  = 4'd6,
        S_MA  = 4'd7,
        S_LD0 = 4'd8,
        S_LD1 = 4'd9,
        S_ST0 = 4'd10,
        S_ST1 = 4'd11,
        S_BL  = 4'd12,
        S_BR  = 4'd13
    } state_e;

    // ALU opcodes used when the unit, not the instruction, picks the operation
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // Register-file write port select
    localparam logic [1:0] WRA_RD  = 2'd0;
    localparam logic [1:0] WRA_R15 = 2'd1;
    localparam logic [1:0] WRA_R14 = 2'd2;

    // Register-file read port A select
    localparam logic [1:0] SRA_RN  = 2'd0;
    localparam logic [1:0] SRA_R15 = 2'd1;

    // Register-file read port B select
    localparam logic [1:0] SRB_R15 = 2'd1;
    localparam logic [1:0] SRB_RD  = 2'd2;
    localparam logic [1:0] SRB_RM  = 2'd3;

    // ALU operand-B select
    localparam logic [1:0] SALUB_MDR    = 2'd0;
    localparam logic [1:0] SALUB_FOUR   = 2'd1;
    localparam logic [1:0] SALUB_BRANCH = 2'd2;
    localparam logic [1:0] SALUB_SHIFT  = 2'd3;

    // Sign/zero-extender select: 12-bit load/store offset
    localparam logic [1:0] SISE_IMM12 = 2'b01;

    // Memory transfer size
    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_WORD = 2'b10;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_cond_eval.sv
// ARM condition-code evaluator (combinational).
// Ports:
//   cond  in  4  instruction condition field IR[31:28]
//   Flags in  4  N=Flags[3], Z=Flags[2], C=Flags[1], V=Flags[0]
//   pass  out 1  1 when the instruction should execute; 1111 never executes
module arm_cond_eval
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] Flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = Flags[3];
    assign z = Flags[2];
    assign c = Flags[1];
    assign v = Flags[0];

    always_comb begin
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = ~(n ^ v);
            COND_LT: pass = n ^ v;
            COND_GT: pass = ~z & ~(n ^ v);
            COND_LE: pass = z | (n ^ v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_control_unit.sv
// Multi-cycle Moore control unit for the ARM datapath:
// fetch, decode/condition check, execute; with a memory-response timeout.
// Ports:
//   CLK, CLR (async active-low reset), IR (instruction), MFC (memory done),
//   Flags (NZCV) in;
//   MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA datapath controls;
//   MAR_EN, SR_EN, SE_EN, MDR_EN, SHT_EN, IR_EN, SGN_EN enables;
//   DataSize, WRA, SRA, SRB, SISE, SALUB selects; ALUA ALU opcode;
//   ABORT one-cycle pulse on memory timeout; STATE debug view of the FSM.
module arm_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int MFC_TIMEOUT = 16,
    parameter int STATE_W     = 4
)
(
    input  logic               CLK,
    input  logic               CLR,
    input  logic [31:0]        IR,
    input  logic               MFC,
    input  logic [3:0]         Flags,
    output logic               MFA,
    output logic               RW_RAM,
    output logic               SALU,
    output logic               RF_CLR,
    output logic               RF_RW,
    output logic               SSAB,
    output logic               SSOP,
    output logic               SMA,
    output logic               STA,
    output logic               MAR_EN,
    output logic               SR_EN,
    output logic               SE_EN,
    output logic               MDR_EN,
    output logic               SHT_EN,
    output logic               IR_EN,
    output logic               SGN_EN,
    output logic [1:0]         DataSize,
    output logic [1:0]         WRA,
    output logic [1:0]         SRA,
    output logic [1:0]         SRB,
    output logic [1:0]         SISE,
    output logic [1:0]         SALUB,
    output logic [3:0]         ALUA,
    output logic               ABORT,
    output logic [STATE_W-1:0] STATE
);

    localparam int CNT_W = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             abort_q;
    logic             cond_pass;
    logic             in_wait;
    logic             timeout;

    arm_cond_eval u_cond (
        .cond  (IR[31:28]),
        .Flags (Flags),
        .pass  (cond_pass)
    );

    assign in_wait = (state == S_F2) || (state == S_LD0) || (state == S_ST1);
    // MFC has priority: a response on the last allowed cycle is not a timeout
    assign timeout = in_wait && !MFC && (wait_cnt == CNT_LAST);

    assign ABORT = abort_q;
    assign STATE = STATE_W'(state);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= S_RST;
            wait_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            state   <= state_next;
            // Registered so the pulse lands in the S_F0 cycle after the abort
            abort_q <= timeout;
            // Counter only survives while parked in the same wait state
            if (in_wait && (state_next == state))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        MFA      = 1'b0;
        RW_RAM   = 1'b0;
        SALU     = 1'b0;
        RF_CLR   = 1'b0;
        RF_RW    = 1'b0;
        SSAB     = 1'b0;
        SSOP     = 1'b0;
        SMA      = 1'b0;
        STA      = 1'b0;
        MAR_EN   = 1'b0;
        SR_EN    = 1'b0;
        SE_EN    = 1'b0;
        MDR_EN   = 1'b0;
        SHT_EN   = 1'b0;
        IR_EN    = 1'b0;
        SGN_EN   = 1'b0;
        DataSize = 2'b00;
        WRA      = 2'b00;
        SRA      = 2'b00;
        SRB      = 2'b00;
        SISE     = 2'b00;
        SALUB    = 2'b00;
        ALUA     = 4'b0000;

        case (state)
            S_RST: begin
                RF_CLR     = 1'b1;
                state_next = S_F0;
            end
            S_F0: begin
                SRB        = SRB_R15;
                SSOP       = 1'b1;
                SALUB      = SALUB_SHIFT;
                ALUA       = ALU_MOV;
                MAR_EN     = 1'b1;
                state_next = S_F1;
            end
            S_F1: begin
                SRA        = SRA_R15;
                SALUB      = SALUB_FOUR;
                ALUA       = ALU_ADD;
                WRA        = WRA_R15;
                RF_RW      = 1'b1;
                MFA        = 1'b1;
                RW_RAM     = 1'b1;
                SMA        = 1'b1;
                MDR_EN     = 1'b1;
                DataSize   = DS_WORD;
                state_next = S_F2;
            end
            S_F2: begin
                MFA      = 1'b1;
                RW_RAM   = 1'b1;
                SMA      = 1'b1;
                MDR_EN   = 1'b1;
                DataSize = DS_WORD;
                if (MFC)
                    state_next = S_F3;
                else if (timeout)
                    state_next = S_F0;
            end
            S_F3: begin
                IR_EN      = 1'b1;
                state_next = S_DEC;
            end
            S_DEC: begin
                if (!cond_pass)
                    state_next = S_F0;
                else if (IR[27:26] == 2'b00)
                    state_next = S_DP;
                else if (IR[27:26] == 2'b01 && !IR[25])
                    state_next = S_MA;
                else if (IR[27:25] == 3'b101)
                    state_next = IR[24] ? S_BL : S_BR;
                else
                    state_next = S_F0;
            end
            S_DP: begin
                SALU   = 1'b1;
                SRA    = SRA_RN;
                SRB    = SRB_RM;
                SALUB  = SALUB_SHIFT;
                WRA    = WRA_RD;
                SHT_EN = 1'b1;
                SSOP   = ~IR[25];
                SE_EN  = IR[25];
                SSAB   = IR[4];
                STA    = IR[25];
                // TST/TEQ/CMP/CMN only update flags
                RF_RW  = (IR[24:23] != 2'b10);
                SR_EN  = IR[20];
                state_next = S_F0;
            end
            S_MA: begin
                SRA        = SRA_RN;
                SE_EN      = 1'b1;
                SISE       = SISE_IMM12;
                SSOP       = 1'b0;
                SALUB      = SALUB_SHIFT;
                ALUA       = IR[23] ? ALU_ADD : ALU_SUB;
                MAR_EN     = 1'b1;
                state_next = IR[20] ? S_LD0 : S_ST0;
            end
            S_LD0: begin
                MFA      = 1'b1;
                RW_RAM   = 1'b1;
                SMA      = 1'b1;
                SGN_EN   = 1'b1;
                MDR_EN   = 1'b1;
                DataSize = IR[22] ? DS_BYTE : DS_WORD;
                if (MFC)
                    state_next = S_LD1;
                else if (timeout)
                    state_next = S_F0;
            end
            S_LD1: begin
                SALUB      = SALUB_MDR;
                ALUA       = ALU_MOV;
                WRA        = WRA_RD;
                RF_RW      = 1'b1;
                state_next = S_F0;
            end
            S_ST0: begin
                SRB        = SRB_RD;
                SSOP       = 1'b1;
                SALUB      = SALUB_SHIFT;
                ALUA       = ALU_MOV;
                SMA        = 1'b0;
                MDR_EN     = 1'b1;
                state_next = S_ST1;
            end
            S_ST1: begin
                MFA      = 1'b1;
                RW_RAM   = 1'b0;
                DataSize = IR[22] ? DS_BYTE : DS_WORD;
                if (MFC || timeout)
                    state_next = S_F0;
            end
            S_BL: begin
                SRB        = SRB_R15;
                SSOP       = 1'b1;
                SALUB      = SALUB_SHIFT;
                ALUA       = ALU_MOV;
                WRA        = WRA_R14;
                RF_RW      = 1'b1;
                state_next = S_BR;
            end
            S_BR: begin
                SRA        = SRA_R15;
                SALUB      = SALUB_BRANCH;
                ALUA       = ALU_ADD;
                WRA        = WRA_R15;
                RF_RW      = 1'b1;
                state_next = S_F0;
            end
            default: state_next = S_RST;
        endcase
    end

endmodule
